// File: rtl/im_loader.sv
// Instruction-memory image loader: takes a length-prefixed big-endian byte stream,
// assembles 32-bit words, writes them to instruction memory and holds the CPU until done.
module im_loader #(
  parameter int ADDR_W    = 8,
  parameter bit HOLD_IDLE = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0]     DEPTH   = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [ADDR_W:0]   idx_reg, idx_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [31:0]       word_reg, word_next;
  logic [15:0]       len_full;
  logic              xfer;

  // byte_ready is decoded from state alone, so xfer never feeds back into byte_ready.
  assign xfer     = byte_valid && byte_ready;
  assign len_full = {len_reg[15:8], byte_data};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) begin
          state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_next   = {byte_data, 8'h00};
          state_next = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_next = len_full;
          idx_next = '0;
          cnt_next = '0;
          if (len_full == 16'd0) begin
            state_next = S_DONE;
          end else if ({16'd0, len_full} > DEPTH) begin
            state_next = S_ERR;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          // Shifting left leaves the first byte of the word in [31:24].
          word_next = {word_reg[23:0], byte_data};
          cnt_next  = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (32'(idx_reg) + 32'd1 == {16'd0, len_reg}) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx_reg + IDX_ONE;
          state_next = S_DATA;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    im_we      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state_reg)
      S_IDLE:   cpu_hold   = HOLD_IDLE;
      S_LEN_HI: byte_ready = 1'b1;
      S_LEN_LO: byte_ready = 1'b1;
      S_DATA:   byte_ready = 1'b1;
      S_WRITE:  im_we      = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:    err        = 1'b1;
      default:  cpu_hold   = 1'b1;
    endcase
  end

  assign im_addr  = 32'({idx_reg, 2'b00});
  assign im_wdata = word_reg;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a per-cycle vector table for the basic load,
// zero-length and overflow cases, then hand sequences for the longer corner cases.
module tb_im_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  im_loader #(.ADDR_W(8), .HOLD_IDLE(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ls;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] wq[$];
  int          rdy_viol = 0;
  int          passed = 0;
  int          total = 0;

  // Write monitor: one entry per cycle with im_we high.
  always @(negedge clock) begin
    if (reset && im_we) begin
      wq.push_back({im_addr, im_wdata});
      if (byte_ready) rdy_viol++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic ls, input logic v, input logic [7:0] d,
                              input logic rdy, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic hold,
                              input logic dn, input logic er);
    vec_t r;
    r.ls = ls; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr;
    r.wdata = wdata; r.hold = hold; r.dn = dn; r.er = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step(input logic ls, input logic v, input logic [7:0] d, output logic acc);
    @(negedge clock);
    load_start = ls;
    byte_valid = v;
    byte_data  = d;
    acc = v && byte_ready;
  endtask

  task automatic send(input logic [7:0] d, input bit rnd);
    logic acc;
    logic v;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1'b0, v, v ? d : ~d, acc);
      got = acc;
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int bound);
    logic acc;
    int n;
    n = 0;
    while (!done && n < bound) begin
      step(1'b0, 1'b0, 8'h00, acc);
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic chk_write(input string nm, input int k, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [63:0] e;
    if (k < wq.size()) begin
      e = wq[k];
      chk({nm, "_addr"}, e[63:32], addr);
      chk({nm, "_data"}, e[31:0], data);
    end else begin
      chk({nm, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    logic        acc;
    logic [7:0]  rb[12];
    logic [31:0] w;

    // Per-cycle table: inputs applied this cycle, outputs expected this cycle.
    //            ls    v     d      rdy   we    addr   wdata          hold  dn    er
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0)); // IDLE
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0)); // LEN_HI
    tbl.push_back(mk(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0)); // LEN_LO
    tbl.push_back(mk(1'b0, 1'b1, 8'h24, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 32'h0, 32'h24010005, 1'b1, 1'b0, 1'b0)); // WRITE
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h18, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4, 32'h00221820, 1'b1, 1'b0, 1'b0)); // WRITE
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0)); // DONE
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0)); // DONE+start
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0)); // LEN_HI
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0)); // LEN_LO=0
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0)); // DONE
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0)); // LEN_HI
    tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0)); // 257
    tbl.push_back(mk(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b1)); // ERR
    tbl.push_back(mk(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b1)); // ERR+start
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0)); // LEN_HI
    tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hDE, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hAD, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hBE, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hEF, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0)); // WRITE
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0)); // DONE

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we",    32'(im_we),      32'd0);
    chk("rst_addr",  im_addr,         32'd0);
    chk("rst_wdata", im_wdata,        32'd0);
    chk("rst_hold",  32'(cpu_hold),   32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_err",   32'(err),        32'd0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      chk($sformatf("v%0d_ready", i), 32'(byte_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_we",    i), 32'(im_we),      32'(tbl[i].we));
      chk($sformatf("v%0d_hold",  i), 32'(cpu_hold),   32'(tbl[i].hold));
      chk($sformatf("v%0d_done",  i), 32'(done),       32'(tbl[i].dn));
      chk($sformatf("v%0d_err",   i), 32'(err),        32'(tbl[i].er));
      if (tbl[i].we) begin
        chk($sformatf("v%0d_addr",  i), im_addr,  tbl[i].addr);
        chk($sformatf("v%0d_wdata", i), im_wdata, tbl[i].wdata);
      end
      load_start = tbl[i].ls;
      byte_valid = tbl[i].v;
      byte_data  = tbl[i].d;
    end
    chk("table_write_count", 32'(wq.size()), 32'd3);

    // Full-depth load: 256 words, bytes from a counter
    wq.delete();
    step(1'b1, 1'b0, 8'h00, acc);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    for (int k = 0; k < 1024; k++) send(8'(k), 1'b0);
    wait_done(20);
    chk("full_write_count", 32'(wq.size()), 32'd256);
    for (int k = 0; k < 256; k++) begin
      w = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
      chk_write($sformatf("full_w%0d", k), k, 32'(4 * k), w);
    end
    if (wq.size() > 0) chk("full_last_addr", wq[wq.size() - 1][63:32], 32'h3FC);
    chk("full_hold", 32'(cpu_hold), 32'd0);

    // Three-word load with random source stalls
    rb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'h0F, 8'hF0,
           8'hCA, 8'hFE, 8'hBA, 8'hBE};
    wq.delete();
    rdy_viol = 0;
    step(1'b1, 1'b0, 8'h00, acc);
    send(8'h00, 1'b1);
    send(8'h03, 1'b1);
    for (int k = 0; k < 12; k++) send(rb[k], 1'b1);
    wait_done(20);
    chk("stall_write_count", 32'(wq.size()), 32'd3);
    chk_write("stall_w0", 0, 32'h0, 32'h11223344);
    chk_write("stall_w1", 1, 32'h4, 32'hA55A0FF0);
    chk_write("stall_w2", 2, 32'h8, 32'hCAFEBABE);
    chk("stall_ready_in_write", 32'(rdy_viol), 32'd0);

    // Reset after two bytes of the first word, then reload
    wq.delete();
    step(1'b1, 1'b0, 8'h00, acc);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    @(negedge clock);
    byte_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready", 32'(byte_ready), 32'd0);
    chk("abort_hold",  32'(cpu_hold),   32'd0);
    chk("abort_wdata", im_wdata,        32'd0);
    chk("abort_done",  32'(done),       32'd0);
    reset = 1'b1;
    chk("abort_no_write", 32'(wq.size()), 32'd0);
    step(1'b1, 1'b0, 8'h00, acc);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b0);
    wait_done(20);
    chk("reload_write_count", 32'(wq.size()), 32'd1);
    chk_write("reload_w0", 0, 32'h0, 32'hDEADBEEF);

    // load_start pulsed mid-DATA must be ignored
    wq.delete();
    step(1'b1, 1'b0, 8'h00, acc);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    step(1'b1, 1'b0, 8'h00, acc);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    wait_done(20);
    chk("midls_write_count", 32'(wq.size()), 32'd2);
    chk_write("midls_w0", 0, 32'h0, 32'h11223344);
    chk_write("midls_w1", 1, 32'h4, 32'h55667788);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
